// File: rtl/unpacker_right.sv
// Wide-to-narrow unpacker: 2-entry wide-word buffer, emits OUT_WIDTH slices LSB first.
// Slice order mirrors the right-shift packer so the pair round-trips a word unchanged.
module unpacker_right #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Reset,
    input  logic                 Packed_EnWr,
    output logic                 Packed_RdyWr,
    input  logic [IN_WIDTH-1:0]  Packed_DatWr,
    output logic                 Unpacked_RdyRd,
    input  logic                 Unpacked_EnRd,
    output logic [OUT_WIDTH-1:0] Unpacked_DatRd,
    output logic                 Unpacked_Last,
    output logic                 Err_Overflow
);
    localparam int NUM_SLICE = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W     = (NUM_SLICE > 1) ? $clog2(NUM_SLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICE - 1);

    typedef logic [NUM_SLICE-1:0][OUT_WIDTH-1:0] slices_t;

    logic [IN_WIDTH-1:0] mem [2];
    logic                wr_ptr, rd_ptr;
    logic [1:0]          cnt;
    logic [IDX_W-1:0]    idx;
    logic                err;

    logic    wr_acc, rd_acc, pop, at_last;
    slices_t cur;

    assign Packed_RdyWr   = (cnt < 2'd2);
    assign Unpacked_RdyRd = (cnt != 2'd0);
    assign at_last        = (idx == LAST_IDX);
    assign wr_acc         = Packed_EnWr & Packed_RdyWr;
    assign rd_acc         = Unpacked_EnRd & Unpacked_RdyRd;
    assign pop            = rd_acc & at_last;

    // View the head word as an array of slices; slice 0 is the LSB end.
    assign cur            = slices_t'(mem[rd_ptr]);
    assign Unpacked_DatRd = cur[idx];
    assign Unpacked_Last  = Unpacked_RdyRd & at_last;
    assign Err_Overflow   = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            idx    <= '0;
            err    <= 1'b0;
        end else if (Reset) begin
            // Flush control state only; stale data is hidden behind cnt==0.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            idx    <= '0;
            err    <= 1'b0;
        end else begin
            if (wr_acc) begin
                mem[wr_ptr] <= Packed_DatWr;
                wr_ptr      <= ~wr_ptr;
            end
            if (Packed_EnWr && !Packed_RdyWr)
                err <= 1'b1;
            if (rd_acc) begin
                if (at_last) begin
                    idx    <= '0;
                    rd_ptr <= ~rd_ptr;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            case ({wr_acc, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
